// File: rtl/axis_pkt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen_pkg
// Brief    : State encoding and default widths for the AXI-Stream packet
//            generator.
// Revision : 1.0 - initial release
// ============================================================================
package axis_pkt_gen_pkg;

    localparam int C_DEF_DATA_WIDTH = 16;
    localparam int C_DEF_LEN_WIDTH  = 8;
    localparam int C_DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen
// Brief    : AXI-Stream packet generator producing incrementing-data packets
//            of fixed length with optional inter-packet gaps.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int P_DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int P_LEN_WIDTH  = C_DEF_LEN_WIDTH,
    parameter int P_CNT_WIDTH  = C_DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [P_LEN_WIDTH-1:0]  cfg_len,
    input  logic [P_LEN_WIDTH-1:0]  cfg_gap,
    input  logic [P_CNT_WIDTH-1:0]  cfg_num_pkts,
    input  logic [P_DATA_WIDTH-1:0] cfg_seed,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [P_CNT_WIDTH-1:0]  pkt_count
);

    localparam logic [P_LEN_WIDTH-1:0]  C_LEN_ONE  = P_LEN_WIDTH'(1);
    localparam logic [P_CNT_WIDTH-1:0]  C_CNT_ONE  = P_CNT_WIDTH'(1);
    localparam logic [P_DATA_WIDTH-1:0] C_DATA_ONE = P_DATA_WIDTH'(1);

    state_t                  r_state;
    logic [P_LEN_WIDTH-1:0]  r_len;
    logic [P_LEN_WIDTH-1:0]  r_gap;
    logic [P_CNT_WIDTH-1:0]  r_num;
    logic [P_LEN_WIDTH-1:0]  r_beat;
    logic [P_LEN_WIDTH-1:0]  r_gap_cnt;
    logic [P_DATA_WIDTH-1:0] r_data;
    logic [P_CNT_WIDTH-1:0]  r_pkt_count;
    logic                    r_stop_pending;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic                    r_busy;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [P_LEN_WIDTH-1:0]  w_len_nxt;
    logic [P_LEN_WIDTH-1:0]  w_gap_nxt;
    logic [P_CNT_WIDTH-1:0]  w_num_nxt;
    logic [P_LEN_WIDTH-1:0]  w_beat_nxt;
    logic [P_LEN_WIDTH-1:0]  w_gap_cnt_nxt;
    logic [P_DATA_WIDTH-1:0] w_data_nxt;
    logic [P_CNT_WIDTH-1:0]  w_pkt_count_nxt;
    logic                    w_stop_pending_nxt;
    logic                    w_tvalid_nxt;
    logic                    w_tlast_nxt;
    logic                    w_done_nxt;
    logic [P_LEN_WIDTH-1:0]  w_beat_inc;
    logic [P_CNT_WIDTH-1:0]  w_pkt_inc;
    logic                    w_run_end;

    always_comb begin
        w_state_nxt        = r_state;
        w_len_nxt          = r_len;
        w_gap_nxt          = r_gap;
        w_num_nxt          = r_num;
        w_beat_nxt         = r_beat;
        w_gap_cnt_nxt      = r_gap_cnt;
        w_data_nxt         = r_data;
        w_pkt_count_nxt    = r_pkt_count;
        w_stop_pending_nxt = r_stop_pending;
        w_tvalid_nxt       = r_tvalid;
        w_tlast_nxt        = r_tlast;
        w_done_nxt         = 1'b0;
        w_beat_inc         = r_beat + C_LEN_ONE;
        // Saturation only matters for endless runs; bounded runs end first.
        w_pkt_inc          = (r_pkt_count == '1) ? r_pkt_count : r_pkt_count + C_CNT_ONE;
        w_run_end          = ((r_num != '0) && (w_pkt_inc == r_num)) || r_stop_pending || stop;

        case (r_state)
            S_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    w_state_nxt        = S_SEND;
                    w_len_nxt          = cfg_len;
                    w_gap_nxt          = cfg_gap;
                    w_num_nxt          = cfg_num_pkts;
                    w_data_nxt         = cfg_seed;
                    w_beat_nxt         = '0;
                    w_pkt_count_nxt    = '0;
                    w_stop_pending_nxt = 1'b0;
                    w_tvalid_nxt       = 1'b1;
                    w_tlast_nxt        = (cfg_len == C_LEN_ONE);
                end
            end

            S_SEND: begin
                if (stop) begin
                    w_stop_pending_nxt = 1'b1;
                end
                // tvalid is always high in SEND, so tready alone marks a transfer.
                if (m_axis_tready) begin
                    w_data_nxt = r_data + C_DATA_ONE;
                    if (r_tlast) begin
                        w_pkt_count_nxt = w_pkt_inc;
                        w_beat_nxt      = '0;
                        if (w_run_end) begin
                            w_state_nxt        = S_IDLE;
                            w_tvalid_nxt       = 1'b0;
                            w_tlast_nxt        = 1'b0;
                            w_stop_pending_nxt = 1'b0;
                            w_done_nxt         = 1'b1;
                        end else if (r_gap == '0) begin
                            w_tlast_nxt = (r_len == C_LEN_ONE);
                        end else begin
                            w_state_nxt   = S_GAP;
                            w_tvalid_nxt  = 1'b0;
                            w_tlast_nxt   = 1'b0;
                            w_gap_cnt_nxt = r_gap - C_LEN_ONE;
                        end
                    end else begin
                        w_beat_nxt  = w_beat_inc;
                        w_tlast_nxt = (w_beat_inc == (r_len - C_LEN_ONE));
                    end
                end
            end

            S_GAP: begin
                if (stop) begin
                    w_state_nxt        = S_IDLE;
                    w_stop_pending_nxt = 1'b0;
                    w_done_nxt         = 1'b1;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt  = S_SEND;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = (r_len == C_LEN_ONE);
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - C_LEN_ONE;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_tvalid_nxt = 1'b0;
                w_tlast_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_gap          <= '0;
            r_num          <= '0;
            r_beat         <= '0;
            r_gap_cnt      <= '0;
            r_data         <= '0;
            r_pkt_count    <= '0;
            r_stop_pending <= 1'b0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_len          <= w_len_nxt;
            r_gap          <= w_gap_nxt;
            r_num          <= w_num_nxt;
            r_beat         <= w_beat_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_data         <= w_data_nxt;
            r_pkt_count    <= w_pkt_count_nxt;
            r_stop_pending <= w_stop_pending_nxt;
            r_tvalid       <= w_tvalid_nxt;
            r_tlast        <= w_tlast_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= w_done_nxt;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_data;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_gen
// Brief    : Self-checking bench for axis_pkt_gen against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_gen;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] cfg_gap;
    logic [CW-1:0] cfg_num_pkts;
    logic [DW-1:0] cfg_seed;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_count;

    int n_cmp = 0;
    int n_err = 0;

    // Observations gathered by the capture task.
    logic [DW-1:0] cap_data[$];
    bit            cap_last[$];
    int            cap_idle[$];
    int            done_cycle;
    int            done_cnt;
    int            last_xfer_cycle;
    int            stop_cycle;
    int            stall_chg;
    logic [CW-1:0] pkt_at_done;
    bit            timed_out;

    axis_pkt_gen #(
        .P_DATA_WIDTH (DW),
        .P_LEN_WIDTH  (LW),
        .P_CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_num_pkts  (cfg_num_pkts),
        .cfg_seed      (cfg_seed),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: beat k of a run carries seed+k, closes a packet every
    // len beats, and is preceded by gap idle cycles when it opens a packet.
    function automatic logic [DW-1:0] m_data(input logic [DW-1:0] seed, input int k);
        return seed + DW'(k);
    endfunction

    function automatic bit m_last(input int len, input int k);
        return (k % len) == (len - 1);
    endfunction

    function automatic int m_idle(input int len, input int gap, input int k);
        return (k != 0 && (k % len) == 0) ? gap : 0;
    endfunction

    // Called at a falling edge; returns at the falling edge where the first
    // beat must already be valid.
    task automatic start_run(input int len, input int gap, input int num, input logic [DW-1:0] seed);
        cfg_len      = LW'(len);
        cfg_gap      = LW'(gap);
        cfg_num_pkts = CW'(num);
        cfg_seed     = seed;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Drives tready/stop/cfg noise each cycle and records what the sink sees.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic capture(input int budget, input int rdy_mode, input int stop_at, input bit stop_gap);
        int            cyc;
        int            idle;
        int            extra;
        bit            stalled;
        logic [DW-1:0] pd;
        logic          pl;
        cap_data.delete();
        cap_last.delete();
        cap_idle.delete();
        done_cycle      = -1;
        done_cnt        = 0;
        last_xfer_cycle = -1;
        stop_cycle      = -1;
        stall_chg       = 0;
        pkt_at_done     = '0;
        cyc = 0; idle = 0; extra = -1; stalled = 1'b0; pd = '0; pl = 1'b0;
        while (cyc < budget && extra != 0) begin
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) begin
                    done_cycle  = cyc;
                    pkt_at_done = pkt_count;
                end
            end
            if (stalled && m_axis_tvalid && (m_axis_tdata !== pd || m_axis_tlast !== pl))
                stall_chg++;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ((cyc % 3) == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            stop = 1'b0;
            if (stop_at >= 0 && stop_cycle < 0) begin
                if (stop_gap ? (!m_axis_tvalid && busy && cap_data.size() >= stop_at)
                             : (m_axis_tvalid && cap_data.size() == stop_at)) begin
                    stop       = 1'b1;
                    stop_cycle = cyc;
                end
            end
            // Configuration churn and stray starts while busy must be ignored.
            cfg_len      = LW'($urandom);
            cfg_gap      = LW'($urandom);
            cfg_num_pkts = CW'($urandom);
            cfg_seed     = DW'($urandom);
            start        = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                cap_idle.push_back(idle);
                last_xfer_cycle = cyc;
                idle = 0;
            end else if (!m_axis_tvalid) begin
                idle++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (done_cycle >= 0 && extra < 0) extra = 3;
            else if (extra > 0) extra--;
            @(negedge clk);
            cyc++;
        end
        timed_out     = (done_cycle < 0);
        start         = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        n_cmp++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h expected 0000", m_axis_tdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (pkt_count !== '0) begin n_err++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        cfg_len = '0; cfg_gap = '0; cfg_num_pkts = CW'(1); cfg_seed = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                n_err++; $display("FAIL zero_len[%0d]: got busy=%b tvalid=%b expected 0 0", i, busy, m_axis_tvalid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        start_run(4, 0, 2, 16'h00FE);
        capture(200, 0, -1, 1'b0);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL b2b_timeout: got no done expected done"); end
        n_cmp++; if (cap_data.size() != 8) begin n_err++; $display("FAIL b2b_count: got %0d expected 8", cap_data.size()); end
        for (int k = 0; k < cap_data.size() && k < 8; k++) begin
            n_cmp++; if (cap_data[k] !== m_data(16'h00FE, k) || cap_last[k] !== m_last(4, k) || cap_idle[k] != 0) begin
                n_err++; $display("FAIL b2b_beat[%0d]: got %h/%b/%0d expected %h/%b/0", k, cap_data[k], cap_last[k], cap_idle[k], m_data(16'h00FE, k), m_last(4, k));
            end
        end
        n_cmp++; if (done_cycle != last_xfer_cycle + 1 || done_cnt != 1) begin
            n_err++; $display("FAIL b2b_done: got cycle %0d count %0d expected cycle %0d count 1", done_cycle, done_cnt, last_xfer_cycle + 1);
        end
        n_cmp++; if (pkt_at_done !== CW'(2)) begin n_err++; $display("FAIL b2b_pkt_count: got %0d expected 2", pkt_at_done); end
    endtask

    task automatic test_gap_wrap();
        start_run(3, 2, 2, 16'hFFFF);
        capture(200, 0, -1, 1'b0);
        n_cmp++; if (timed_out || cap_data.size() != 6) begin
            n_err++; $display("FAIL gap_count: got %0d beats timeout=%b expected 6 beats", cap_data.size(), timed_out);
        end
        for (int k = 0; k < cap_data.size() && k < 6; k++) begin
            n_cmp++; if (cap_data[k] !== m_data(16'hFFFF, k) || cap_last[k] !== m_last(3, k) || cap_idle[k] != m_idle(3, 2, k)) begin
                n_err++; $display("FAIL gap_beat[%0d]: got %h/%b/%0d expected %h/%b/%0d", k, cap_data[k], cap_last[k], cap_idle[k], m_data(16'hFFFF, k), m_last(3, k), m_idle(3, 2, k));
            end
        end
        n_cmp++; if (pkt_at_done !== CW'(2)) begin n_err++; $display("FAIL gap_pkt_count: got %0d expected 2", pkt_at_done); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] seed;
        seed = DW'($urandom);
        start_run(5, 1, 1, seed);
        capture(300, 1, -1, 1'b0);
        n_cmp++; if (timed_out || cap_data.size() != 5) begin
            n_err++; $display("FAIL bp_count: got %0d beats timeout=%b expected 5 beats", cap_data.size(), timed_out);
        end
        for (int k = 0; k < cap_data.size() && k < 5; k++) begin
            n_cmp++; if (cap_data[k] !== m_data(seed, k) || cap_last[k] !== m_last(5, k)) begin
                n_err++; $display("FAIL bp_beat[%0d]: got %h/%b expected %h/%b", k, cap_data[k], cap_last[k], m_data(seed, k), m_last(5, k));
            end
        end
        n_cmp++; if (stall_chg != 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_chg); end
        n_cmp++; if (done_cycle != last_xfer_cycle + 1) begin n_err++; $display("FAIL bp_done: got cycle %0d expected %0d", done_cycle, last_xfer_cycle + 1); end
    endtask

    task automatic test_stop_mid_packet();
        logic [DW-1:0] seed;
        seed = DW'($urandom);
        start_run(2, 0, 0, seed);
        capture(200, 0, 4, 1'b0);
        n_cmp++; if (timed_out || cap_data.size() != 6) begin
            n_err++; $display("FAIL stop_count: got %0d beats timeout=%b expected 6 beats", cap_data.size(), timed_out);
        end
        for (int k = 0; k < cap_data.size() && k < 6; k++) begin
            n_cmp++; if (cap_data[k] !== m_data(seed, k) || cap_last[k] !== m_last(2, k)) begin
                n_err++; $display("FAIL stop_beat[%0d]: got %h/%b expected %h/%b", k, cap_data[k], cap_last[k], m_data(seed, k), m_last(2, k));
            end
        end
        n_cmp++; if (pkt_at_done !== CW'(3) || done_cnt != 1) begin
            n_err++; $display("FAIL stop_pkt_count: got %0d done_cnt %0d expected 3 done_cnt 1", pkt_at_done, done_cnt);
        end
        n_cmp++; if (done_cycle != last_xfer_cycle + 1) begin n_err++; $display("FAIL stop_done: got cycle %0d expected %0d", done_cycle, last_xfer_cycle + 1); end
    endtask

    task automatic test_stop_in_gap();
        logic [DW-1:0] seed;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL stop_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        seed = DW'($urandom);
        start_run(2, 3, 0, seed);
        capture(200, 0, 4, 1'b1);
        n_cmp++; if (timed_out || cap_data.size() != 4) begin
            n_err++; $display("FAIL gapstop_count: got %0d beats timeout=%b expected 4 beats", cap_data.size(), timed_out);
        end
        n_cmp++; if (stop_cycle < 0 || done_cycle != stop_cycle + 1) begin
            n_err++; $display("FAIL gapstop_done: got cycle %0d expected %0d", done_cycle, stop_cycle + 1);
        end
        n_cmp++; if (pkt_at_done !== CW'(2)) begin n_err++; $display("FAIL gapstop_pkt_count: got %0d expected 2", pkt_at_done); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] seed;
        int            seen_done;
        seed = DW'($urandom);
        start_run(4, 0, 1, seed);
        m_axis_tready = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== m_data(seed, 1)) begin
            n_err++; $display("FAIL rstmid_beat2: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, m_data(seed, 1));
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0 || pkt_count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async: got tvalid=%b pkt=%0d busy=%b done=%b expected 0 0 0 0", m_axis_tvalid, pkt_count, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        m_axis_tready = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || m_axis_tvalid) seen_done++;
            @(negedge clk);
        end
        n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", seen_done); end
        start_run(4, 0, 1, seed);
        capture(200, 0, -1, 1'b0);
        n_cmp++; if (cap_data.size() != 4 || cap_idle.size() == 0 || cap_data[0] !== seed || cap_idle[0] != 0) begin
            n_err++; $display("FAIL rstmid_restart: got %0d beats first %h expected 4 beats first %h", cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 16'hxxxx, seed);
        end
    endtask

    task automatic test_random();
        int            len, gap, num;
        logic [DW-1:0] seed;
        for (int r = 0; r < 6; r++) begin
            len  = $urandom_range(1, 6);
            gap  = $urandom_range(0, 3);
            num  = $urandom_range(1, 4);
            seed = DW'($urandom);
            start_run(len, gap, num, seed);
            capture(800, 2, -1, 1'b0);
            n_cmp++; if (timed_out || cap_data.size() != len * num) begin
                n_err++; $display("FAIL rand%0d_count: got %0d beats timeout=%b expected %0d", r, cap_data.size(), timed_out, len * num);
            end
            for (int k = 0; k < cap_data.size() && k < len * num; k++) begin
                n_cmp++; if (cap_data[k] !== m_data(seed, k) || cap_last[k] !== m_last(len, k) || cap_idle[k] != m_idle(len, gap, k)) begin
                    n_err++; $display("FAIL rand%0d_beat[%0d]: got %h/%b/%0d expected %h/%b/%0d", r, k, cap_data[k], cap_last[k], cap_idle[k], m_data(seed, k), m_last(len, k), m_idle(len, gap, k));
                end
            end
            n_cmp++; if (stall_chg != 0 || pkt_at_done !== CW'(num) || done_cnt != 1) begin
                n_err++; $display("FAIL rand%0d_end: got stall=%0d pkt=%0d done_cnt=%0d expected 0 %0d 1", r, stall_chg, pkt_at_done, done_cnt, num);
            end
        end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; m_axis_tready = 1'b0;
        cfg_len = '0; cfg_gap = '0; cfg_num_pkts = '0; cfg_seed = '0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero_len();
        test_back_to_back();
        test_gap_wrap();
        test_backpressure();
        test_stop_mid_packet();
        test_stop_in_gap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
